// File: rtl/ula_pkg.sv
// Shared encodings for the registered ALU: op codes and FSM states.
package ula_pkg;

  // op[2]=0 keeps the legacy 2-bit {x,y} encoding of the combinational ALU.
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_AND = 3'b001,
    OP_OR  = 3'b010,
    OP_NOT = 3'b011,
    OP_SUB = 3'b100,
    OP_ADC = 3'b101,
    OP_XOR = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ula_nb_seq_if.sv
// Operand/result handshake bundle between the operand stage and writeback.
interface ula_nb_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c;
  logic             ov;
  logic             z;
  logic             n;

  // Producer/consumer side (operand stage + writeback).
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, s, c, ov, z, n
  );

  // ALU side.
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, s, c, ov, z, n
  );
endinterface

// File: rtl/ula_mul_seq.sv
// Unsigned shift-add multiplier: one partial-product step per cycle,
// WIDTH steps after start, then done for one cycle with the full product.
module ula_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]      cnt_q;
  logic               run_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;   // {partial high, remaining multiplier bits}
  logic [WIDTH:0]     hi_sum;

  // Add the multiplicand into the high half when the current multiplier bit is set.
  always_comb begin
    hi_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (acc_q[0]) hi_sum = hi_sum + {1'b0, mcand_q};
  end

  // Step counter and accumulator; the counter stops at zero and never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      run_q   <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
    end else if (start_i) begin
      cnt_q   <= CW'(WIDTH);
      run_q   <= 1'b1;
      mcand_q <= a_i;
      acc_q   <= {{WIDTH{1'b0}}, b_i};
    end else if (run_q) begin
      if (cnt_q != '0) begin
        acc_q <= {hi_sum, acc_q[WIDTH-1:1]};
        cnt_q <= cnt_q - 1'b1;
      end else begin
        run_q <= 1'b0;
      end
    end
  end

  assign busy_o = run_q;
  assign done_o = run_q && (cnt_q == '0);
  assign prod_o = acc_q;

endmodule

// File: rtl/ula_nb_seq.sv
// Registered WIDTH-bit ALU with valid/ready on both sides, a persistent
// carry for chained ADC and a sequential multiplier for MUL.
module ula_nb_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  ula_nb_seq_if.slave bus
);

  localparam int M = WIDTH - 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   s_q;
  logic               c_q, ov_q, z_q, n_q, cy_q;
  logic               load_alu, mul_start, mul_done, mul_busy;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH-1:0]   alu_s;
  logic               alu_c, alu_ov, alu_arith, cin;
  logic [WIDTH:0]     add_x, sub_x;

  // Single-cycle ops, computed straight from the presented operands.
  always_comb begin
    cin       = (bus.op == OP_ADC) ? cy_q : 1'b0;
    add_x     = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, cin};
    sub_x     = {1'b0, bus.a} - {1'b0, bus.b};
    alu_s     = '0;
    alu_c     = 1'b0;
    alu_ov    = 1'b0;
    alu_arith = 1'b0;
    case (bus.op)
      OP_ADD, OP_ADC: begin
        alu_s     = add_x[M:0];
        alu_c     = add_x[WIDTH];
        alu_ov    = (bus.a[M] == bus.b[M]) && (add_x[M] != bus.a[M]);
        alu_arith = 1'b1;
      end
      OP_SUB: begin
        alu_s     = sub_x[M:0];
        alu_c     = sub_x[WIDTH];   // borrow out == a < b unsigned
        alu_ov    = (bus.a[M] != bus.b[M]) && (sub_x[M] != bus.a[M]);
        alu_arith = 1'b1;
      end
      OP_AND:  alu_s = bus.a & bus.b;
      OP_OR:   alu_s = bus.a | bus.b;
      OP_XOR:  alu_s = bus.a ^ bus.b;
      OP_NOT:  alu_s = ~bus.a;
      default: alu_s = '0;
    endcase
  end

  // Next state and accept decode; DONE with out_ready behaves like IDLE.
  always_comb begin
    state_d   = state_q;
    load_alu  = 1'b0;
    mul_start = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_IDLE || bus.out_ready) begin
          if (bus.in_valid) begin
            if (bus.op == OP_MUL) begin
              mul_start = 1'b1;
              state_d   = S_BUSY;
            end else begin
              load_alu = 1'b1;
              state_d  = S_DONE;
            end
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_BUSY:  if (mul_done) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, result/flag registers and the carry chained into ADC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      c_q     <= 1'b0;
      ov_q    <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      cy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_alu) begin
        s_q  <= alu_s;
        c_q  <= alu_c;
        ov_q <= alu_ov;
        z_q  <= (alu_s == '0);
        n_q  <= alu_s[M];
        if (alu_arith) cy_q <= alu_c;
      end else if (state_q == S_BUSY && mul_done) begin
        s_q  <= prod[M:0];
        c_q  <= 1'b0;
        ov_q <= |prod[2*WIDTH-1:WIDTH];
        z_q  <= (prod[M:0] == '0);
        n_q  <= prod[M];
      end
    end
  end

  ula_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mul_start),
    .a_i     (bus.a),
    .b_i     (bus.b),
    .busy_o  (mul_busy),
    .done_o  (mul_done),
    .prod_o  (prod)
  );

  assign bus.in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.s         = s_q;
  assign bus.c         = c_q;
  assign bus.ov        = ov_q;
  assign bus.z         = z_q;
  assign bus.n         = n_q;

endmodule
